// File: rtl/logic_unit_pkg.sv
// -----------------------------------------------------------------------------
// logic_unit_pkg
// Shared constants for the pipelined bitwise logic unit: opcode encodings and
// default WIDTH / STAGES values used by logic_unit_pipe and its stage slice.
// -----------------------------------------------------------------------------
package logic_unit_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOTA = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_STAGES = 2;

endpackage

// File: rtl/logic_unit_stage.sv
// -----------------------------------------------------------------------------
// logic_unit_stage
// One valid/ready register slice of the logic unit pipeline. Holds a result
// word plus its error flag. The slice loads whenever it is empty or its
// content is leaving this cycle, so empty slots fill even when everything
// downstream is stalled.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready upstream handshake
//   in_y, in_err        upstream result and error flag
//   out_valid/out_ready downstream handshake
//   y, err              registered result and error flag
// -----------------------------------------------------------------------------
module logic_unit_stage
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  logic             vld_q;
  logic [WIDTH-1:0] y_q;
  logic             err_q;

  // Ready is combinational from downstream ready: no skid buffer.
  assign in_ready = !vld_q || out_ready;

  // Register stage: data only loads on an accepted word, so a stalled or
  // drained slot keeps its last contents stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      y_q   <= '0;
      err_q <= 1'b0;
    end else if (in_ready) begin
      vld_q <= in_valid;
      if (in_valid) begin
        y_q   <= in_y;
        err_q <= in_err;
      end
    end
  end

  assign out_valid = vld_q;
  assign y         = y_q;
  assign err       = err_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
// Pipelined WIDTH-bit bitwise logic unit. The opcode-selected function is
// evaluated combinationally on the inputs, then carried through STAGES
// valid/ready register slices. Latency is STAGES cycles at full throughput,
// empty slots collapse, and backpressure propagates combinationally to
// in_ready.
//
// Parameters: WIDTH (1..64), STAGES (1..4)
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  operand handshake
//   a, b, op             operands and function select (sampled on transfer)
//   out_valid/out_ready  result handshake
//   y, err               result and illegal-opcode flag (from the last stage)
//   xfer_cnt, err_cnt    saturating output-transfer / error-transfer counters,
//                        present only when LOGIC_UNIT_STATS_EN is defined
// -----------------------------------------------------------------------------
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             err
`ifdef LOGIC_UNIT_STATS_EN
  ,
  output logic [15:0]      xfer_cnt,
  output logic [15:0]      err_cnt
`endif
);

  // Returns {err, result}.
  function automatic logic [WIDTH:0] decode(input logic [2:0] f,
                                            input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] z);
    case (f)
      OP_AND:  return {1'b0, x & z};
      OP_OR:   return {1'b0, x | z};
      OP_NAND: return {1'b0, ~(x & z)};
      OP_NOR:  return {1'b0, ~(x | z)};
      OP_XOR:  return {1'b0, x ^ z};
      OP_XNOR: return {1'b0, ~(x ^ z)};
      OP_NOTA: return {1'b0, ~x};
      default: return {1'b1, {WIDTH{1'b0}}};
    endcase
  endfunction

  // Index k is the input of slice k; index STAGES is the pipe output.
  logic             vld [STAGES+1];
  logic             rdy [STAGES+1];
  logic             er  [STAGES+1];
  logic [WIDTH-1:0] dat [STAGES+1];

  // Function evaluation ahead of the first register stage
  assign {er[0], dat[0]} = decode(op, a, b);
  assign vld[0]          = in_valid;
  assign in_ready        = rdy[0];
  assign rdy[STAGES]     = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic_unit_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (vld[k]),
      .in_ready  (rdy[k]),
      .in_y      (dat[k]),
      .in_err    (er[k]),
      .out_valid (vld[k+1]),
      .out_ready (rdy[k+1]),
      .y         (dat[k+1]),
      .err       (er[k+1])
    );
  end

  assign out_valid = vld[STAGES];
  assign y         = dat[STAGES];
  assign err       = er[STAGES];

`ifdef LOGIC_UNIT_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Statistics: counters step on the edge that completes an output transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt <= '0;
      err_cnt  <= '0;
    end else if (out_valid && out_ready) begin
      xfer_cnt <= sat_inc(xfer_cnt);
      if (err) err_cnt <= sat_inc(err_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_pipe
// Self-checking bench: a STAGES=2 instance for the main scenarios and a
// STAGES=3 instance for bubble collapse. Expected results come from a
// per-bit truth-table model and a FIFO scoreboard. Defining
// LOGIC_UNIT_STATS_EN also exercises the transfer counters.
// -----------------------------------------------------------------------------
module tb_logic_unit_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, err;
  logic [W-1:0] a = '0, b = '0, y;
  logic [2:0]   op = '0;

  logic         in_valid3 = 1'b0, in_ready3, out_valid3, out_ready3 = 1'b0, err3;
  logic [W-1:0] a3 = '0, b3 = '0, y3;
  logic [2:0]   op3 = '0;

`ifdef LOGIC_UNIT_STATS_EN
  logic [15:0]  xfer_cnt, err_cnt, xfer_cnt3, err_cnt3;
`endif

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(W), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .err(err)
`ifdef LOGIC_UNIT_STATS_EN
    , .xfer_cnt(xfer_cnt), .err_cnt(err_cnt)
`endif
  );

  logic_unit_pipe #(.WIDTH(W), .STAGES(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .a(a3), .b(b3), .op(op3), .out_valid(out_valid3), .out_ready(out_ready3),
    .y(y3), .err(err3)
`ifdef LOGIC_UNIT_STATS_EN
    , .xfer_cnt(xfer_cnt3), .err_cnt(err_cnt3)
`endif
  );

  // Model: each gate is a 4-entry truth table indexed by {a_bit, b_bit}.
  function automatic logic [W:0] ref_model(input logic [2:0] f,
                                           input logic [W-1:0] x,
                                           input logic [W-1:0] z);
    logic [3:0]   tt;
    logic [W-1:0] r;
    case (f)
      3'd0: tt = 4'b1000;
      3'd1: tt = 4'b1110;
      3'd2: tt = 4'b0111;
      3'd3: tt = 4'b0001;
      3'd4: tt = 4'b0110;
      3'd5: tt = 4'b1001;
      3'd6: tt = 4'b0011;
      default: tt = 4'b0000;
    endcase
    for (int i = 0; i < W; i++) r[i] = tt[{x[i], z[i]}];
    return {(f == 3'd7), r};
  endfunction

  // Advance one cycle on the main DUT; called at a falling edge with inputs set.
  task automatic step(output logic i_f, output logic o_f,
                      output logic [W-1:0] oy, output logic oe);
    #1;
    i_f = in_valid && in_ready;
    o_f = out_valid && out_ready;
    oy  = y;
    oe  = err;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || y !== '0 || err !== 1'b0 || out_valid3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b y=%h err=%b out_valid3=%b, want 0/00/0/0",
               out_valid, y, err, out_valid3);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || in_ready3 !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: in_ready=%b in_ready3=%b, want 1/1", in_ready, in_ready3);
    end
    @(negedge clk);
  endtask

  task automatic test_opcode_sweep();
    logic [W-1:0] tbl [8];
    logic i_f, o_f, oe;
    logic [W-1:0] oy;
    tbl = '{8'h4A, 8'hDF, 8'hB5, 8'h20, 8'h95, 8'h6A, 8'h35, 8'h00};
    out_ready = 1'b1;
    a = 8'hCA;
    b = 8'h5F;
    for (int s = 0; s < 10; s++) begin
      in_valid = (s < 8);
      op = 3'(s);
      step(i_f, o_f, oy, oe);
      if (s < 2) begin
        checks++;
        if (o_f !== 1'b0) begin
          errors++;
          $display("FAIL sweep_latency step %0d: out_valid=%b, want 0", s, o_f);
        end
      end else begin
        checks++;
        if (o_f !== 1'b1 || oy !== tbl[s-2] || oe !== (s - 2 == 7)) begin
          errors++;
          $display("FAIL sweep_op%0d: valid=%b y=%h err=%b, want 1 y=%h err=%b",
                   s - 2, o_f, oy, oe, tbl[s-2], (s - 2 == 7));
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic i_f, o_f, oe;
    logic [W-1:0] oy;
    logic [W:0] e;
    int first = -1, last = -1, got = 0;
    out_ready = 1'b1;
    for (int s = 0; s < 14; s++) begin
      in_valid = (s < 10);
      a  = W'($urandom);
      b  = W'($urandom);
      op = 3'($urandom_range(0, 7));
      step(i_f, o_f, oy, oe);
      if (i_f) exp_q.push_back(ref_model(op, a, b));
      checks++;
      if (i_f !== (s < 10)) begin
        errors++;
        $display("FAIL b2b_in_fire step %0d: got %b, want %b", s, i_f, (s < 10));
      end
      if (o_f) begin
        if (first < 0) first = s;
        last = s;
        got++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : {1'b1, {W{1'bx}}};
        checks++;
        if ({oe, oy} !== e) begin
          errors++;
          $display("FAIL b2b_data step %0d: err=%b y=%h, want err=%b y=%h", s, oe, oy, e[W], e[W-1:0]);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (first != 2 || last != 11 || got != 10) begin
      errors++;
      $display("FAIL b2b_window: first=%0d last=%0d count=%0d, want 2 11 10", first, last, got);
    end
  endtask

  task automatic test_backpressure();
    logic i_f, o_f, oe;
    logic [W-1:0] oy;
    logic [W:0] e;
    int acc = 0, got = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int s = 0; s < 6; s++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      op = 3'($urandom_range(0, 7));
      step(i_f, o_f, oy, oe);
      if (i_f) begin
        exp_q.push_back(ref_model(op, a, b));
        acc++;
      end
      if (s >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || {oe, oy} !== exp_q[0]) begin
          errors++;
          $display("FAIL bp_hold step %0d: valid=%b err=%b y=%h, want 1 err=%b y=%h",
                   s, out_valid, oe, oy, exp_q[0][W], exp_q[0][W-1:0]);
        end
      end
    end
    #1;
    checks++;
    if (acc != 2 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: accepted=%0d in_ready=%b, want 2 0", acc, in_ready);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      step(i_f, o_f, oy, oe);
      if (o_f) begin
        got++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : {1'b1, {W{1'bx}}};
        checks++;
        if ({oe, oy} !== e) begin
          errors++;
          $display("FAIL bp_drain: err=%b y=%h, want err=%b y=%h", oe, oy, e[W], e[W-1:0]);
        end
      end
    end
    checks++;
    if (got != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain_count: drained=%0d left=%0d, want 2 0", got, exp_q.size());
    end
  endtask

  task automatic test_full_passthrough();
    logic i_f, o_f, oe;
    logic [W-1:0] oy;
    logic [W:0] e;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int s = 0; s < 7; s++) begin
      out_ready = (s >= 2);
      a  = W'($urandom);
      b  = W'($urandom);
      op = 3'($urandom_range(0, 7));
      step(i_f, o_f, oy, oe);
      if (i_f) exp_q.push_back(ref_model(op, a, b));
      if (s >= 2) begin
        checks++;
        if (i_f !== 1'b1 || o_f !== 1'b1) begin
          errors++;
          $display("FAIL full_simul step %0d: in_fire=%b out_fire=%b, want 1 1", s, i_f, o_f);
        end
      end
      if (o_f) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : {1'b1, {W{1'bx}}};
        checks++;
        if ({oe, oy} !== e) begin
          errors++;
          $display("FAIL full_data step %0d: err=%b y=%h, want err=%b y=%h", s, oe, oy, e[W], e[W-1:0]);
        end
      end
    end
    out_ready = 1'b0;
    step(i_f, o_f, oy, oe);
    checks++;
    if (i_f !== 1'b0 || exp_q.size() != 2) begin
      errors++;
      $display("FAIL full_occupancy: in_fire=%b queued=%0d, want 0 2", i_f, exp_q.size());
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int s = 0; s < 6; s++) begin
      step(i_f, o_f, oy, oe);
      if (o_f) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : {1'b1, {W{1'bx}}};
        checks++;
        if ({oe, oy} !== e) begin
          errors++;
          $display("FAIL full_drain: err=%b y=%h, want err=%b y=%h", oe, oy, e[W], e[W-1:0]);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_drain_count: left=%0d, want 0", exp_q.size());
    end
  endtask

  task automatic test_bubble_collapse();
    logic [W:0] q3[$];
    logic [W:0] e;
    logic fire;
    logic pattern [7];
    int got = 0, first = -1, last = -1;
    pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    out_ready3 = 1'b0;
    for (int s = 0; s < 7; s++) begin
      in_valid3 = pattern[s];
      a3  = W'($urandom);
      b3  = W'($urandom);
      op3 = 3'($urandom_range(0, 6));
      #1;
      fire = in_valid3 && in_ready3;
      if (fire) q3.push_back(ref_model(op3, a3, b3));
      if (s == 3 || s == 5 || s == 6) begin
        checks++;
        if (in_ready3 !== (s != 6)) begin
          errors++;
          $display("FAIL bubble_ready step %0d: in_ready=%b, want %b", s, in_ready3, (s != 6));
        end
      end
      @(negedge clk);
    end
    in_valid3  = 1'b0;
    out_ready3 = 1'b1;
    for (int s = 0; s < 6; s++) begin
      #1;
      if (out_valid3) begin
        if (first < 0) first = s;
        last = s;
        got++;
        e = (q3.size() > 0) ? q3.pop_front() : {1'b1, {W{1'bx}}};
        checks++;
        if ({err3, y3} !== e) begin
          errors++;
          $display("FAIL bubble_data: err=%b y=%h, want err=%b y=%h", err3, y3, e[W], e[W-1:0]);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (got != 3 || first != 0 || last != 2) begin
      errors++;
      $display("FAIL bubble_drain: count=%0d first=%0d last=%0d, want 3 0 2", got, first, last);
    end
    out_ready3 = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    logic i_f, o_f, oe;
    logic [W-1:0] oy;
    int seen = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int s = 0; s < 2; s++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      op = 3'($urandom_range(0, 6));
      step(i_f, o_f, oy, oe);
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_stall_loaded: out_valid=%b, want 1", out_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || y !== '0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: out_valid=%b y=%h err=%b, want 0 00 0", out_valid, y, err);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step(i_f, o_f, oy, oe);
      if (o_f) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_discard: outputs after reset=%0d, want 0", seen);
    end
    exp_q.delete();
  endtask

`ifdef LOGIC_UNIT_STATS_EN
  task automatic test_stats();
    logic i_f, o_f, oe;
    logic [W-1:0] oy;
    logic [2:0] ops [5];
    ops = '{3'd0, 3'd7, 3'd3, 3'd7, 3'd6};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int s = 0; s < 9; s++) begin
      in_valid = (s < 5);
      op = (s < 5) ? ops[s] : 3'd0;
      a  = W'($urandom);
      b  = W'($urandom);
      step(i_f, o_f, oy, oe);
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (xfer_cnt !== 16'd5 || err_cnt !== 16'd2) begin
      errors++;
      $display("FAIL stats_count: xfer=%0d err=%0d, want 5 2", xfer_cnt, err_cnt);
    end
    @(negedge clk);
    in_valid = 1'b1;
    op = 3'd7;
    for (int s = 0; s < 65540; s++) step(i_f, o_f, oy, oe);
    in_valid = 1'b0;
    for (int s = 0; s < 4; s++) step(i_f, o_f, oy, oe);
    #1;
    checks++;
    if (xfer_cnt !== 16'hFFFF || err_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL stats_saturate: xfer=%h err=%h, want ffff ffff", xfer_cnt, err_cnt);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_opcode_sweep();
    test_back_to_back();
    test_backpressure();
    test_full_passthrough();
    test_bubble_collapse();
    test_reset_mid_stall();
`ifdef LOGIC_UNIT_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
